chanmux_select: RTL and testbench

- Parametrised channel selector that replaces the loopback user logic in the channelizer's chanmux NoC block.
- Accepts a time-interleaved sample stream (one sample per channel, round-robin, channel 0 first).
- Forwards only the channels enabled in a programmable mask and regenerates packet boundaries.
- Sits between the axi_wrapper m_axis and s_axis ports. Configuration comes from the settings bus.

---
 rtl/chanmux_pkg.sv | 19 +
 rtl/chanmux_if.sv | 25 ++
 rtl/chanmux_cfg_regs.sv | 97 +++++++++
 rtl/chanmux_select.sv | 107 ++++++++++
 tb/tb_chanmux_select.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/chanmux_pkg.sv
// chanmux channel selector: shared register map and sizing helpers.
// Offsets are relative to the block's settings-register base.
package chanmux_pkg;

  localparam int unsigned REG_NUM_CHANS = 0;
  localparam int unsigned REG_SPP       = 1;
  localparam int unsigned REG_CTRL      = 2;
  localparam int unsigned REG_MASK      = 3;

  localparam int unsigned CTRL_ALIGN  = 0;
  localparam int unsigned CTRL_RESYNC = 1;

  function automatic int unsigned mask_words(
    input int unsigned chan_log2
  );
    return ((1 << chan_log2) + 31) / 32;
  endfunction

endpackage

// File: rtl/chanmux_if.sv
// chanmux channel selector: sample stream bundle.
// chan is only produced by the output side of the selector.
interface chanmux_if #(
  parameter int WIDTH     = 32,
  parameter int CHAN_LOG2 = 6
);
  import chanmux_pkg::*;

  logic [WIDTH-1:0]     tdata;
  logic                 tlast;
  logic                 tvalid;
  logic                 tready;
  logic [CHAN_LOG2-1:0] chan;

  modport master (
    output tdata, tlast, tvalid, chan,
    input  tready
  );

  modport slave (
    input  tdata, tlast, tvalid,
    output tready
  );

endinterface

// File: rtl/chanmux_cfg_regs.sv
// chanmux channel selector: staged/active settings and resync pulse.
// During the resync cycle the staged values are presented directly.
module chanmux_cfg_regs
  import chanmux_pkg::*;
#(
  parameter int CHAN_LOG2 = 6,
  parameter int SR_BASE   = 128,
  parameter int SPP_W     = 16
) (
  input  logic                      ce_clk,
  input  logic                      ce_rst,
  input  logic                      set_stb,
  input  logic [7:0]                set_addr,
  input  logic [31:0]               set_data,
  input  logic                      commit,
  output logic [CHAN_LOG2:0]        num_chans,
  output logic [SPP_W-1:0]          spp,
  output logic                      align,
  output logic [(1<<CHAN_LOG2)-1:0] mask,
  output logic                      resync
);

  localparam int MAXCH = 1 << CHAN_LOG2;
  localparam int NW    = mask_words(CHAN_LOG2);
  localparam int MW    = NW * 32;
  localparam logic [31:0] MAXCH_W = MAXCH;
  localparam logic [CHAN_LOG2:0] N_MAX =
    MAXCH_W[CHAN_LOG2:0];

  logic [CHAN_LOG2:0] n_stg, n_act, n_wr;
  logic [SPP_W-1:0]   spp_stg, spp_act;
  logic               align_stg, align_act;
  logic [MW-1:0]      mask_stg, mask_act;
  logic               resync_q;
  logic [7:0]         off;
  logic               in_range;

  assign off = set_addr - 8'(SR_BASE);
  assign in_range = (set_addr >= 8'(SR_BASE))
                 && (off < 8'(REG_MASK + NW));

  always_comb begin
    n_wr = N_MAX;
    if (set_data != '0 && set_data <= MAXCH_W)
      n_wr = set_data[CHAN_LOG2:0];
  end

  always_ff @(posedge ce_clk) begin
    if (ce_rst) begin
      n_stg     <= N_MAX;
      spp_stg   <= '0;
      align_stg <= 1'b0;
      mask_stg  <= '1;
      resync_q  <= 1'b0;
    end else begin
      resync_q <= 1'b0;
      if (set_stb && in_range) begin
        unique case (1'b1)
          off == 8'(REG_NUM_CHANS): n_stg <= n_wr;
          off == 8'(REG_SPP):
            spp_stg <= set_data[SPP_W-1:0];
          off == 8'(REG_CTRL): begin
            align_stg <= set_data[CTRL_ALIGN];
            resync_q  <= set_data[CTRL_RESYNC];
          end
          default: begin
            for (int k = 0; k < NW; k++)
              if (off == 8'(REG_MASK + k))
                mask_stg[k*32 +: 32] <= set_data;
          end
        endcase
      end
    end
  end

  always_ff @(posedge ce_clk) begin
    if (ce_rst) begin
      n_act     <= N_MAX;
      spp_act   <= '0;
      align_act <= 1'b0;
      mask_act  <= '1;
    end else if (commit) begin
      n_act     <= n_stg;
      spp_act   <= spp_stg;
      align_act <= align_stg;
      mask_act  <= mask_stg;
    end
  end

  assign num_chans = resync_q ? n_stg : n_act;
  assign spp       = resync_q ? spp_stg : spp_act;
  assign align     = resync_q ? align_stg : align_act;
  assign mask      = resync_q ? mask_stg[MAXCH-1:0]
                              : mask_act[MAXCH-1:0];
  assign resync    = resync_q;

endmodule

// File: rtl/chanmux_select.sv
// chanmux channel selector: forwards masked channels of an
// interleaved stream through a one-deep output register.
module chanmux_select
  import chanmux_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int CHAN_LOG2 = 6,
  parameter int SR_BASE   = 128,
  parameter int SPP_W     = 16
) (
  input  logic        ce_clk,
  input  logic        ce_rst,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  chanmux_if.slave    i,
  chanmux_if.master   o
);

  localparam int MAXCH = 1 << CHAN_LOG2;

  logic [CHAN_LOG2:0]   num_chans;
  logic [SPP_W-1:0]     spp;
  logic                 align;
  logic [MAXCH-1:0]     mask;
  logic                 resync;

  logic [CHAN_LOG2-1:0] chan_idx, idx_eff, idx_last;
  logic [SPP_W-1:0]     out_cnt, cnt_eff;
  logic                 pend, pend_eff;
  logic                 sel, acc, emit;
  logic                 boundary, commit, last_eff;

  chanmux_cfg_regs #(
    .CHAN_LOG2 (CHAN_LOG2),
    .SR_BASE   (SR_BASE),
    .SPP_W     (SPP_W)
  ) u_cfg (
    .ce_clk    (ce_clk),
    .ce_rst    (ce_rst),
    .set_stb   (set_stb),
    .set_addr  (set_addr),
    .set_data  (set_data),
    .commit    (commit),
    .num_chans (num_chans),
    .spp       (spp),
    .align     (align),
    .mask      (mask),
    .resync    (resync)
  );

  // A resync cycle behaves as the start of a fresh frame.
  assign idx_eff  = resync ? '0 : chan_idx;
  assign cnt_eff  = resync ? '0 : out_cnt;
  assign pend_eff = resync ? 1'b0 : pend;

  assign idx_last = CHAN_LOG2'(num_chans - 1'b1);
  assign sel      = mask[idx_eff];
  assign i.tready = ~sel | ~o.tvalid | o.tready;
  assign acc      = i.tvalid & i.tready;
  assign emit     = acc & sel;
  assign boundary = acc & ((idx_eff == idx_last)
                         | (align & i.tlast));
  assign commit   = boundary | resync;
  assign last_eff = (spp == '0) ? (i.tlast | pend_eff)
                                : (cnt_eff >= spp - 1'b1);

  always_ff @(posedge ce_clk) begin
    if (ce_rst) begin
      chan_idx <= '0;
      out_cnt  <= '0;
      pend     <= 1'b0;
      o.tvalid <= 1'b0;
      o.tdata  <= '0;
      o.tlast  <= 1'b0;
      o.chan   <= '0;
    end else begin
      if (boundary)
        chan_idx <= '0;
      else if (acc)
        chan_idx <= idx_eff + 1'b1;
      else
        chan_idx <= idx_eff;

      if (emit) begin
        pend <= 1'b0;
        if (spp != '0)
          out_cnt <= last_eff ? '0 : cnt_eff + 1'b1;
        else
          out_cnt <= cnt_eff;
      end else begin
        out_cnt <= cnt_eff;
        pend    <= pend_eff | (acc & i.tlast);
      end

      if (emit) begin
        o.tvalid <= 1'b1;
        o.tdata  <= i.tdata;
        o.tlast  <= last_eff;
        o.chan   <= idx_eff;
      end else if (o.tready) begin
        o.tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_chanmux_select.sv
// chanmux_select bench: config table, hand sequences and
// randomized streams against a transaction-level model.
module tb_chanmux_select;
  import chanmux_pkg::*;

  localparam int WIDTH = 32;
  localparam int CL    = 6;
  localparam int BASE  = 128;
  localparam int MAXCH = 64;

  logic        ce_clk = 1'b0;
  logic        ce_rst;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;

  chanmux_if #(.WIDTH(WIDTH), .CHAN_LOG2(CL)) in_if ();
  chanmux_if #(.WIDTH(WIDTH), .CHAN_LOG2(CL)) out_if ();

  assign in_if.chan = '0;

  chanmux_select #(
    .WIDTH(WIDTH), .CHAN_LOG2(CL),
    .SR_BASE(BASE), .SPP_W(16)
  ) dut (
    .ce_clk   (ce_clk),
    .ce_rst   (ce_rst),
    .set_stb  (set_stb),
    .set_addr (set_addr),
    .set_data (set_data),
    .i        (in_if),
    .o        (out_if)
  );

  always #5 ce_clk = ~ce_clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] d;
    logic        l;
    logic [5:0]  ch;
  } beat_t;
  beat_t expq[$];

  // model state: staged/active config and stream position
  int          stg_n, act_n, stg_spp, act_spp;
  logic        stg_al, act_al;
  logic [63:0] stg_mask, act_mask;
  int          m_idx, m_nemit;
  logic        m_pend;

  bit   seen[256];
  bit   seen_last[256];
  int   seen_chan[256];
  int   n_emit, n_last;
  logic hold_v;
  beat_t hold;

  task automatic chk(input bit ok, input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic void model_reset();
    stg_n = MAXCH; act_n = MAXCH;
    stg_spp = 0; act_spp = 0;
    stg_al = 0; act_al = 0;
    stg_mask = '1; act_mask = '1;
    m_idx = 0; m_nemit = 0; m_pend = 0;
  endfunction

  function automatic void load_active();
    act_n = stg_n; act_spp = stg_spp;
    act_al = stg_al; act_mask = stg_mask;
  endfunction

  function automatic void model_write(input logic [7:0] a,
                                      input logic [31:0] w);
    int off;
    off = int'(a) - BASE;
    if (off == REG_NUM_CHANS)
      stg_n = (w == 0 || w > MAXCH) ? MAXCH : int'(w);
    else if (off == REG_SPP)
      stg_spp = int'(w[15:0]);
    else if (off == REG_CTRL) begin
      stg_al = w[0];
      if (w[1]) begin
        load_active();
        m_idx = 0; m_nemit = 0; m_pend = 0;
      end
    end else if (off == REG_MASK)
      stg_mask[31:0] = w;
    else if (off == REG_MASK + 1)
      stg_mask[63:32] = w;
  endfunction

  function automatic void model_beat(input logic [31:0] d,
                                     input logic l);
    beat_t b;
    if (act_mask[m_idx]) begin
      b.d  = d;
      b.ch = 6'(m_idx);
      if (act_spp == 0) b.l = l || m_pend;
      else b.l = (m_nemit % act_spp) == act_spp - 1;
      expq.push_back(b);
      m_nemit++;
      m_pend = 0;
    end else if (l) begin
      m_pend = 1;
    end
    if (m_idx == act_n - 1 || (act_al && l)) begin
      m_idx = 0;
      load_active();
    end else begin
      m_idx++;
    end
  endfunction

  task automatic clear_seen();
    for (int k = 0; k < 256; k++) begin
      seen[k] = 0; seen_last[k] = 0; seen_chan[k] = -1;
    end
    n_emit = 0; n_last = 0;
  endtask

  task automatic step(input logic v, input logic [31:0] d,
                      input logic l, input logic stb,
                      input logic [7:0] a,
                      input logic [31:0] w,
                      input logic rdy, output logic acc);
    beat_t e;
    @(negedge ce_clk);
    in_if.tvalid = v; in_if.tdata = d; in_if.tlast = l;
    set_stb = stb; set_addr = a; set_data = w;
    out_if.tready = rdy;
    #1;
    if (hold_v)
      chk(out_if.tvalid && out_if.tdata == hold.d &&
          out_if.tlast == hold.l && out_if.chan == hold.ch,
          "stall_hold",
          {out_if.tvalid, out_if.tlast, out_if.chan, out_if.tdata},
          {1'b1, hold.l, hold.ch, hold.d});
    if (out_if.tvalid && out_if.tready) begin
      if (expq.size() == 0) begin
        chk(0, "unexpected_out", 64'(out_if.tdata), 0);
      end else begin
        e = expq.pop_front();
        chk(out_if.tdata == e.d && out_if.tlast == e.l &&
            out_if.chan == e.ch, "out_beat",
            {out_if.tlast, out_if.chan, out_if.tdata},
            {e.l, e.ch, e.d});
      end
      n_emit++;
      if (out_if.tlast) n_last++;
      if (out_if.tdata < 256) begin
        seen[out_if.tdata[7:0]]      = 1;
        seen_last[out_if.tdata[7:0]] = out_if.tlast;
        seen_chan[out_if.tdata[7:0]] = int'(out_if.chan);
      end
    end
    hold_v = out_if.tvalid && !out_if.tready;
    hold.d = out_if.tdata; hold.l = out_if.tlast;
    hold.ch = out_if.chan;
    acc = v && in_if.tready;
    if (acc) model_beat(d, l);
    if (stb) model_write(a, w);
  endtask

  task automatic send(input logic [31:0] d, input logic l,
                      input int pct, input logic stb = 0,
                      input logic [7:0] a = 0,
                      input logic [31:0] w = 0);
    logic acc, rdy;
    int n;
    n = 0;
    do begin
      rdy = ($urandom_range(0, 99) < pct);
      step(1, d, l, stb, a, w, rdy, acc);
      n++;
    end while (!acc && n < 200);
    if (!acc) chk(0, "accept_timeout", 64'(n), 200);
  endtask

  task automatic wr(input int off, input logic [31:0] w);
    logic acc;
    step(0, 0, 0, 1, 8'(BASE + off), w, 1, acc);
  endtask

  task automatic drain();
    logic acc;
    int n;
    n = 0;
    while (expq.size() != 0 && n < 200) begin
      step(0, 0, 0, 0, 0, 0, 1, acc);
      n++;
    end
    chk(expq.size() == 0, "drain", 64'(expq.size()), 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 1, acc);
  endtask

  task automatic do_reset();
    @(negedge ce_clk);
    ce_rst = 1; in_if.tvalid = 0; in_if.tdata = 0;
    in_if.tlast = 0; set_stb = 0; set_addr = 0;
    set_data = 0; out_if.tready = 1;
    repeat (2) @(negedge ce_clk);
    ce_rst = 0;
    model_reset();
    expq.delete();
    hold_v = 0;
    clear_seen();
  endtask

  typedef struct {
    int          nch;
    logic [31:0] m0, m1;
    int          spp, nbeats, exp_emit, exp_last;
  } vec_t;
  vec_t tv[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int nch;
    tv[0] = '{4, 32'h5, '1, 0, 16, 8, 0};
    tv[1] = '{4, 32'h5, '1, 3, 16, 8, 2};
    tv[2] = '{0, '1, '1, 0, 64, 64, 0};
    tv[3] = '{100, 32'h3, 32'h0, 0, 128, 4, 0};
    tv[4] = '{2, 32'h1, '1, 4, 20, 10, 2};
    tv[5] = '{4, 32'h0, 32'h0, 0, 16, 0, 0};
    tv[6] = '{3, 32'h6, 32'h0, 2, 15, 10, 5};

    do_reset();
    #1;
    chk(out_if.tvalid == 0, "rst_tvalid", 64'(out_if.tvalid), 0);
    chk(out_if.tlast == 0, "rst_tlast", 64'(out_if.tlast), 0);
    chk(out_if.tdata == 0, "rst_tdata", 64'(out_if.tdata), 0);
    chk(out_if.chan == 0, "rst_chan", 64'(out_if.chan), 0);
    chk(in_if.tready == 1, "rst_tready", 64'(in_if.tready), 1);

    // default config: plain pass-through
    send(0, 0, 100);
    @(posedge ce_clk); #1;
    chk(out_if.tvalid && out_if.tdata == 0, "latency1",
        {out_if.tvalid, out_if.tdata}, {1'b1, 32'h0});
    for (int v = 1; v < 128; v++)
      send(v, v == 63 || v == 127, 100);
    drain();
    chk(seen_last[63] == 1, "pt_last63", 64'(seen_last[63]), 1);
    chk(seen_last[127] == 1, "pt_last127", 64'(seen_last[127]), 1);
    chk(seen_last[62] == 0, "pt_last62", 64'(seen_last[62]), 0);
    chk(seen_chan[100] == 36, "pt_chan100", 64'(seen_chan[100]), 36);
    chk(n_emit == 128, "pt_count", 64'(n_emit), 128);

    foreach (tv[t]) begin
      do_reset();
      wr(REG_NUM_CHANS, tv[t].nch);
      wr(REG_MASK, tv[t].m0);
      wr(REG_MASK + 1, tv[t].m1);
      wr(REG_SPP, tv[t].spp);
      wr(REG_CTRL, 32'h2);
      for (int v = 0; v < tv[t].nbeats; v++) send(v, 0, 100);
      drain();
      chk(n_emit == tv[t].exp_emit, $sformatf("tv%0d_emit", t),
          64'(n_emit), 64'(tv[t].exp_emit));
      chk(n_last == tv[t].exp_last, $sformatf("tv%0d_last", t),
          64'(n_last), 64'(tv[t].exp_last));
      if (t == 0)
        chk(seen_chan[6] == 2, "tv0_chan6", 64'(seen_chan[6]), 2);
    end

    // tlast on a discarded beat carries to the next emitted beat
    do_reset();
    wr(REG_NUM_CHANS, 2); wr(REG_MASK, 1); wr(REG_MASK + 1, 0);
    wr(REG_CTRL, 2);
    for (int v = 0; v < 10; v++) send(v, v == 5, 100);
    drain();
    chk(seen_last[6] == 1, "pend_last6", 64'(seen_last[6]), 1);
    chk(seen_last[8] == 0, "pend_clr8", 64'(seen_last[8]), 0);
    chk(seen_last[4] == 0, "pend_none4", 64'(seen_last[4]), 0);

    // mask write mid-frame waits for the next frame
    do_reset();
    wr(REG_NUM_CHANS, 4); wr(REG_CTRL, 2);
    send(0, 0, 100);
    send(1, 0, 100, 1, 8'(BASE + REG_MASK), 32'h2);
    for (int v = 2; v < 12; v++) send(v, 0, 100);
    drain();
    chk(seen[2] && seen[3], "mid_old", {seen[2], seen[3]}, 2'b11);
    chk(!seen[4] && seen[5], "mid_new", {seen[4], seen[5]}, 2'b01);
    chk(!seen[8] && seen[9], "mid_new2", {seen[8], seen[9]}, 2'b01);

    // backpressure with full mask, then align on tlast
    do_reset();
    wr(REG_NUM_CHANS, 8); wr(REG_CTRL, 2);
    for (int v = 0; v < 200; v++) send($urandom, 0, 50);
    drain();
    chk(n_emit == 200, "bp_count", 64'(n_emit), 200);
    wr(REG_CTRL, 3);
    clear_seen();
    for (int v = 0; v < 4; v++) send(v, v == 2, 100);
    drain();
    chk(seen_chan[2] == 2, "align_ch2", 64'(seen_chan[2]), 2);
    chk(seen_chan[3] == 0, "align_ch0", 64'(seen_chan[3]), 0);

    // randomized configurations and traffic
    for (int it = 0; it < 5; it++) begin
      do_reset();
      nch = $urandom_range(1, 8);
      wr(REG_NUM_CHANS, nch);
      wr(REG_MASK, $urandom_range(0, 255));
      wr(REG_MASK + 1, $urandom);
      wr(REG_SPP, $urandom_range(0, 4));
      wr(REG_CTRL, {30'h0, 1'b1, 1'($urandom_range(0, 1))});
      for (int v = 0; v < 150; v++) begin
        if ($urandom_range(0, 39) == 0) begin
          r = $urandom;
          if (r[0]) wr(REG_MASK, $urandom_range(0, 255));
          else wr(REG_CTRL, {30'h0, 1'b1, r[1]});
        end
        send($urandom, $urandom_range(0, 6) == 0, 60);
      end
      drain();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
